// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: a fetch stage and a MEM stage share one
// registered memory interface with wait states. Data wins, but fetch gets a turn after a data burst.
module mem_port_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              resetn,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // pipeline stalls
  output logic              stall_if,
  output logic              stall_mem,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  // debug view of the FSM (0 = IDLE, 1 = ACCESS)
  output logic              dbg_state
);

  // Handshake: a requester holds req (and its address/data) until the cycle in
  // which gnt pulses; gnt is only issued in a decision cycle (IDLE, or ACCESS
  // with mem_ready) and the access is presented on mem_* from the next edge.

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_BURST);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        streak_q, streak_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic decision;
  logic fetch_wins;
  logic grant_if;
  logic grant_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    streak_d    = streak_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant_if    = 1'b0;
    grant_d     = 1'b0;

    decision   = (state_q == S_IDLE) || mem_ready;
    fetch_wins = if_req && (!d_req || (streak_q == STREAK_MAX));

    // Read completion returns data to whoever owned the finishing access.
    if ((state_q == S_ACCESS) && mem_ready && !mem_we_q) begin
      if (owner_q == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = mem_rdata;
      end else begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = mem_rdata;
      end
    end

    if (decision) begin
      if (fetch_wins) begin
        grant_if    = 1'b1;
        state_d     = S_ACCESS;
        owner_d     = OWN_IF;
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
        streak_d    = '0;
      end else if (d_req) begin
        grant_d     = 1'b1;
        state_d     = S_ACCESS;
        owner_d     = OWN_D;
        mem_en_d    = 1'b1;
        mem_we_d    = d_we;
        mem_addr_d  = d_addr;
        mem_wdata_d = d_wdata;
        // The streak only counts data grants that actually made fetch wait.
        if (!if_req) begin
          streak_d = '0;
        end else if (streak_q != STREAK_MAX) begin
          streak_d = streak_q + 4'd1;
        end
      end else begin
        state_d  = S_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      streak_q    <= streak_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Grants are combinational, so they are masked while reset is asserted.
  assign if_gnt    = resetn && grant_if;
  assign d_gnt     = resetn && grant_d;
  assign stall_if  = if_req && !if_gnt;
  assign stall_mem = d_req && !d_gnt;

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign dbg_state = state_q;

endmodule
